// File: rtl/aes_pkg.sv
// AES helper package: state/column types, GF(2^8) multiply helpers and FSM encoding
// shared by the iterative MixColumns block (mixcolumn_iter) and its column engine.
package aes_pkg;

  typedef logic [127:0] aes_state_t;
  typedef logic [31:0]  aes_col_t;

  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } mc_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gf_mulB(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_mulD(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gf_mulE(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

endpackage

// File: rtl/mixcolumn_col.sv
// Combinational single-column MixColumns engine. Forward [02 03 01 01] circulant always;
// the inverse [0E 0B 0D 09] circulant only when MIXCOL_INV_EN is defined.
module mixcolumn_col
  import aes_pkg::*;
(
  input  aes_col_t col_i,
  input  logic     inv_i,
  output aes_col_t col_o
);

  logic [7:0] a0, a1, a2, a3;
  aes_col_t   fwd;

  assign a0 = col_i[31:24];
  assign a1 = col_i[23:16];
  assign a2 = col_i[15:8];
  assign a3 = col_i[7:0];

  assign fwd = {gf_mul2(a0) ^ gf_mul3(a1) ^ a2 ^ a3,
                a0 ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3,
                a0 ^ a1 ^ gf_mul2(a2) ^ gf_mul3(a3),
                gf_mul3(a0) ^ a1 ^ a2 ^ gf_mul2(a3)};

`ifdef MIXCOL_INV_EN
  aes_col_t inv;

  assign inv = {gf_mulE(a0) ^ gf_mulB(a1) ^ gf_mulD(a2) ^ gf_mul9(a3),
                gf_mul9(a0) ^ gf_mulE(a1) ^ gf_mulB(a2) ^ gf_mulD(a3),
                gf_mulD(a0) ^ gf_mul9(a1) ^ gf_mulE(a2) ^ gf_mulB(a3),
                gf_mulB(a0) ^ gf_mulD(a1) ^ gf_mul9(a2) ^ gf_mulE(a3)};

  assign col_o = inv_i ? inv : fwd;
`else
  logic unused_inv;

  assign unused_inv = inv_i;
  assign col_o      = fwd;
`endif

endmodule

// File: rtl/mixcolumn_iter.sv
// Iterative AES MixColumns: one 128-bit state over 4/COLS_PER_CYCLE beats with a
// valid/ready handshake on both sides. Optional inverse transform via MIXCOL_INV_EN.
module mixcolumn_iter
  import aes_pkg::*;
#(
  parameter int unsigned COLS_PER_CYCLE = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic         inv_i,
  input  logic [127:0] mixcolumn_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] mixcolumn_o
);

  localparam int unsigned BEATS = 4 / COLS_PER_CYCLE;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mixcolumn_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  mc_state_e  state_q;
  logic [BW-1:0] beat_q;
  aes_state_t data_q, data_d;
  logic       inv_q, inv_sel, out_valid_q, accept;
  aes_col_t   cols [4];
  aes_col_t   cols_d [4];
  aes_col_t   eng_in [COLS_PER_CYCLE];
  aes_col_t   eng_out [COLS_PER_CYCLE];

`ifdef MIXCOL_INV_EN
  assign inv_sel = inv_i;
`else
  logic unused_inv;

  assign unused_inv = inv_i;
  assign inv_sel    = 1'b0;
`endif

  assign in_ready_o  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready_i);
  assign accept      = in_valid_i & in_ready_o;
  assign out_valid_o = out_valid_q;
  assign mixcolumn_o = data_q;

  // Unpack the data register into columns and select this beat's engine inputs
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      cols[i] = data_q[127 - 32*i -: 32];
    end
    for (int unsigned g = 0; g < COLS_PER_CYCLE; g++) begin
      eng_in[g] = cols[2'(beat_q * COLS_PER_CYCLE + g)];
    end
  end

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_eng
    mixcolumn_col u_col (
      .col_i (eng_in[g]),
      .inv_i (inv_q),
      .col_o (eng_out[g])
    );
  end

  // Write the transformed columns back in place and repack the state
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      cols_d[i] = cols[i];
    end
    for (int unsigned g = 0; g < COLS_PER_CYCLE; g++) begin
      cols_d[2'(beat_q * COLS_PER_CYCLE + g)] = eng_out[g];
    end
    data_d = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      data_d[127 - 32*i -: 32] = cols_d[i];
    end
  end

  // Control FSM with registered data, mode and output-valid
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      data_q      <= '0;
      inv_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            data_q  <= mixcolumn_i;
            inv_q   <= inv_sel;
            beat_q  <= '0;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          data_q <= data_d;
          if (beat_q == BW'(BEATS - 1)) begin
            beat_q      <= '0;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            beat_q <= beat_q + BW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
            // release and accept in the same cycle: skip IDLE so there is no bubble
            if (in_valid_i) begin
              data_q  <= mixcolumn_i;
              inv_q   <= inv_sel;
              beat_q  <= '0;
              state_q <= ST_BUSY;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mixcolumn_iter.sv
// Scoreboard bench for mixcolumn_iter: one DUT per legal COLS_PER_CYCLE (1, 2, 4),
// directed vectors, backpressure, mid-operation reset and 1000 random states each.
module tb_mixcolumn_iter;

`ifdef MIXCOL_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_tot = 0;

  always #5 clk = ~clk;

  // cycle counter: value seen at a negedge = number of rising edges so far
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input int c, input string nm, input bit ok,
                              input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (ok) n_pass++;
    else $display("FAIL c%0d_%s: got %h expected %h", c, nm, act, exp);
  endfunction

  // GF(2^8) multiply: carry-less product, then reduction modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= ({8'h00, a} << i);
    for (int k = 15; k >= 8; k--) if (p[k]) p ^= (16'h011B << (k - 8));
    return p[7:0];
  endfunction

  // Reference MixColumns: out[r][j] = XOR_c M[r][c] * in[c][j], M circulant on a base row
  function automatic logic [127:0] ref_mix(input logic [127:0] s, input bit inv);
    logic [7:0]   base [4];
    logic [7:0]   acc;
    logic [127:0] r;
    if (inv) base = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
    else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
    r = '0;
    for (int j = 0; j < 4; j++) begin
      for (int row = 0; row < 4; row++) begin
        acc = '0;
        for (int c = 0; c < 4; c++)
          acc ^= gmul(base[(c - row + 4) % 4], s[127 - 8*(4*j + c) -: 8]);
        r[127 - 8*(4*j + row) -: 8] = acc;
      end
    end
    return r;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_inst
    localparam int unsigned C = (gi == 0) ? 1 : (gi == 1) ? 2 : 4;
    localparam int unsigned B = 4 / C;

    logic         rst_n, in_valid, in_ready, inv, out_valid, out_ready;
    logic [127:0] din, dout;
    logic [127:0] exp_q [$];
    int           acc_q [$];
    int           sent = 0;
    bit           fin = 1'b0;

    mixcolumn_iter #(.COLS_PER_CYCLE(C)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .inv_i       (inv),
      .mixcolumn_i (din),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .mixcolumn_o (dout)
    );

    // accept observer: pushes the model's answer and the accepting edge number
    initial forever begin
      @(negedge clk);
      if (rst_n && in_valid && in_ready) begin
        exp_q.push_back(ref_mix(din, INV_EN ? inv : 1'b0));
        acc_q.push_back(cyc + 1);
        sent++;
      end
    end

    // monitor: latency, hold-while-stalled, ordering and data against the scoreboard
    initial begin : mon
      bit           seen, stall;
      logic [127:0] held;
      seen = 0; stall = 0; held = '0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          seen = 0;
          stall = 0;
        end else if (out_valid) begin
          if (stall) chk(C, "hold", dout == held, dout, held);
          chk(C, "spurious_valid", exp_q.size() != 0, 128'(exp_q.size()), 128'd1);
          if (exp_q.size() != 0) begin
            if (!seen) begin
              seen = 1;
              chk(C, "latency", cyc == acc_q[0] + int'(B), 128'(cyc), 128'(acc_q[0] + int'(B)));
            end
            if (out_ready) begin
              chk(C, "data", dout == exp_q[0], dout, exp_q[0]);
              void'(exp_q.pop_front());
              void'(acc_q.pop_front());
              seen = 0;
              stall = 0;
            end else begin
              stall = 1;
              held = dout;
            end
          end
        end
      end
    end

    task automatic wait_valid(input string nm);
      int n;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk(C, {nm, "_timeout"}, out_valid, 128'(out_valid), 128'd1);
    endtask

    task automatic directed(input logic [127:0] d, input bit iv, input logic [127:0] expv,
                            input string nm);
      @(posedge clk); #1;
      din = d; inv = iv; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0; inv = ~iv;
      wait_valid(nm);
      chk(C, nm, dout == expv, dout, expv);
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
    endtask

    // driver: directed phases, then randomized streaming
    initial begin
      logic [127:0] va, vb;
      int           base_sent, guard, n;
      rst_n = 1'b0; in_valid = 1'b0; inv = 1'b0; din = '0; out_ready = 1'b0;
      @(posedge clk); @(negedge clk);
      chk(C, "rst_valid", out_valid == 1'b0, 128'(out_valid), 128'd0);
      chk(C, "rst_data", dout == '0, dout, '0);
      chk(C, "rst_ready", in_ready == 1'b1, 128'(in_ready), 128'd1);
      @(posedge clk); #1 rst_n = 1'b1;

      directed(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0,
               128'h046681e5e0cb199a48f8d37a2806264c, "fwd_vec1");
      directed(128'hdb135345f20a225c01010101c6c6c6c6, 1'b0,
               128'h8e4da1bc9fdc589d01010101c6c6c6c6, "fwd_vec2");
      directed(128'h046681e5e0cb199a48f8d37a2806264c, 1'b1,
               INV_EN ? 128'hd4bf5d30e0b452aeb84111f11e2798e5
                      : ref_mix(128'h046681e5e0cb199a48f8d37a2806264c, 1'b0), "inv_vec");

      // backpressure, then release plus new accept in the same cycle
      va = {$urandom, $urandom, $urandom, $urandom};
      vb = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1 din = va; inv = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0; din = vb;
      wait_valid("bp");
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        chk(C, "bp_data", dout == ref_mix(va, 1'b0), dout, ref_mix(va, 1'b0));
        chk(C, "bp_valid", out_valid == 1'b1, 128'(out_valid), 128'd1);
        chk(C, "bp_ready", in_ready == 1'b0, 128'(in_ready), 128'd0);
      end
      @(posedge clk); #1 out_ready = 1'b1; in_valid = 1'b1; din = vb;
      @(negedge clk);
      chk(C, "no_bubble_ready", in_ready == 1'b1, 128'(in_ready), 128'd1);
      @(posedge clk); #1 out_ready = 1'b0; in_valid = 1'b0;
      wait_valid("bp2");
      chk(C, "bp_second", dout == ref_mix(vb, 1'b0), dout, ref_mix(vb, 1'b0));
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;

      // reset two beats into a state
      @(posedge clk); #1 din = va; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      exp_q.delete();
      acc_q.delete();
      @(negedge clk);
      chk(C, "midrst_valid", out_valid == 1'b0, 128'(out_valid), 128'd0);
      chk(C, "midrst_data", dout == '0, dout, '0);
      chk(C, "midrst_ready", in_ready == 1'b1, 128'(in_ready), 128'd1);
      directed(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0,
               128'h046681e5e0cb199a48f8d37a2806264c, "post_rst");

      // random streaming with random valid/ready/inv
      base_sent = sent;
      guard = 0;
      while (sent < base_sent + 1000 && guard < 30000) begin
        @(posedge clk); #1;
        in_valid  = ($urandom_range(0, 3) != 0);
        din       = {$urandom, $urandom, $urandom, $urandom};
        inv       = $urandom_range(0, 1) == 1;
        out_ready = ($urandom_range(0, 3) != 0);
        guard++;
      end
      chk(C, "stream_count", sent >= base_sent + 1000, 128'(sent - base_sent), 128'd1000);
      @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
        @(posedge clk);
        n++;
      end
      chk(C, "drain", exp_q.size() == 0, 128'(exp_q.size()), 128'd0);
      fin = 1'b1;
    end
  end

  initial begin
    int n;
    n = 0;
    while (!(g_inst[0].fin && g_inst[1].fin && g_inst[2].fin) && n < 90000) begin
      @(posedge clk);
      n++;
    end
    if (!(g_inst[0].fin && g_inst[1].fin && g_inst[2].fin)) begin
      n_tot++;
      $display("FAIL global_timeout: got unfinished expected all finished");
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
